// File: rtl/tlc_safety_monitor.sv
// tlc_safety_monitor: safety stage placed after the traffic light controller.
// Samples the four controller lamp buses, passes legal patterns through with a
// 2-cycle latency and latches a sticky fault (flashing red on every head) on any
// illegal encoding, conflicting greens, illegal colour step, short yellow or stall.
// Leaving FAULT needs fault_clr followed by an all-red STARTUP interval.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   L2R_in..R2L_in [2:0]     controller lamp buses (001 green, 010 yellow, 100 red)
//   fault_clr                single-cycle request to leave FAULT
//   L2R_out..R2L_out [2:0]   registered lamp drive, same encoding, 000 = dark
//   fault                    high while in FAULT
//   fault_code [2:0]         latched cause: 1 enc, 2 conflict, 3 seq, 4 short yellow, 5 stall
//   mon_state [1:0]          0 STARTUP, 1 RUN, 2 FAULT
module tlc_safety_monitor #(
  parameter int unsigned MIN_Y      = 3,
  parameter int unsigned WDOG_CYC   = 16,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned ALLRED_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] L2R_in,
  input  logic [2:0] D2R_in,
  input  logic [2:0] L2D_in,
  input  logic [2:0] R2L_in,
  input  logic       fault_clr,
  output logic [2:0] L2R_out,
  output logic [2:0] D2R_out,
  output logic [2:0] L2D_out,
  output logic [2:0] R2L_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] mon_state
);

  typedef enum logic [1:0] {StStartup = 2'd0, StRun = 2'd1, StFault = 2'd2} state_e;

  localparam logic [2:0] Green  = 3'b001;
  localparam logic [2:0] Yellow = 3'b010;
  localparam logic [2:0] Red    = 3'b100;
  localparam logic [2:0] Dark   = 3'b000;

  localparam logic [7:0] MinY         = 8'(MIN_Y);
  localparam logic [7:0] WdogCyc      = 8'(WDOG_CYC);
  localparam logic [7:0] FlashHalfM1  = 8'(FLASH_HALF - 1);
  localparam logic [7:0] AllredCycM1  = 8'(ALLRED_CYC - 1);

  // Bus index: 0 = L2R, 1 = D2R, 2 = L2D, 3 = R2L.
  logic [3:0][2:0] in_bus, s_q, p_q, out_q, out_d;
  logic [3:0][7:0] ycnt_q, ycnt_d;
  logic [7:0]      stall_q, stall_d, acnt_q, acnt_d, fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic [2:0]      code_q, code_d, viol_code;
  logic            enc_err, conf_err, seq_err, shorty_err, stall_err, viol, clr;
  state_e          state_q, state_d;

  assign in_bus = {R2L_in, L2D_in, D2R_in, L2R_in};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Safety checks on the sample S and previous sample P.
  always_comb begin
    enc_err    = 1'b0;
    seq_err    = 1'b0;
    shorty_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!(s_q[i] == Green || s_q[i] == Yellow || s_q[i] == Red)) enc_err = 1'b1;
      if (s_q[i] != p_q[i] &&
          !((p_q[i] == Green  && s_q[i] == Yellow) ||
            (p_q[i] == Yellow && s_q[i] == Red)    ||
            (p_q[i] == Red    && s_q[i] == Green))) seq_err = 1'b1;
      // ycnt_q holds the number of completed yellow cycles of the run just ended.
      if (p_q[i] == Yellow && s_q[i] != Yellow && ycnt_q[i] < MinY) shorty_err = 1'b1;
    end
    conf_err  = (s_q[1] != Red && (s_q[0] != Red || s_q[2] != Red || s_q[3] != Red)) ||
                (s_q[3] != Red && s_q[2] != Red);
    stall_err = (stall_q >= WdogCyc);
    if (enc_err)         viol_code = 3'd1;
    else if (conf_err)   viol_code = 3'd2;
    else if (seq_err)    viol_code = 3'd3;
    else if (shorty_err) viol_code = 3'd4;
    else if (stall_err)  viol_code = 3'd5;
    else                 viol_code = 3'd0;
    viol = (viol_code != 3'd0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStartup: begin
        if (viol)                       state_d = StFault;
        else if (acnt_q >= AllredCycM1) state_d = StRun;
      end
      StRun:   if (viol)      state_d = StFault;
      StFault: if (fault_clr) state_d = StStartup;
      default:                state_d = StStartup;
    endcase
  end

  // Output register and counter next values.
  always_comb begin
    clr     = (state_q == StFault) && fault_clr;
    out_d   = {Red, Red, Red, Red};
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    code_d  = code_q;

    for (int i = 0; i < 4; i++) begin
      ycnt_d[i] = (clr || s_q[i] != Yellow) ? 8'd0 : sat_inc(ycnt_q[i]);
    end
    stall_d = (clr || s_q != p_q) ? 8'd0 : sat_inc(stall_q);
    acnt_d  = (state_q == StStartup && state_d == StStartup) ? sat_inc(acnt_q) : 8'd0;

    case (state_d)
      StRun: out_d = s_q;
      StFault: begin
        if (state_q != StFault) begin
          // Entering FAULT: latch the cause, start the flash with red lit.
          code_d  = viol_code;
          fcnt_d  = 8'd0;
          phase_d = 1'b1;
        end else if (fcnt_q >= FlashHalfM1) begin
          fcnt_d  = 8'd0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d  = fcnt_q + 8'd1;
        end
        out_d = phase_d ? {Red, Red, Red, Red} : {Dark, Dark, Dark, Dark};
      end
      default: begin
        if (clr) begin
          code_d  = 3'd0;
          fcnt_d  = 8'd0;
          phase_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStartup;
      s_q     <= {Red, Red, Red, Red};
      p_q     <= {Red, Red, Red, Red};
      out_q   <= {Red, Red, Red, Red};
      ycnt_q  <= '0;
      stall_q <= 8'd0;
      acnt_q  <= 8'd0;
      fcnt_q  <= 8'd0;
      phase_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      s_q     <= in_bus;
      p_q     <= s_q;
      out_q   <= out_d;
      ycnt_q  <= ycnt_d;
      stall_q <= stall_d;
      acnt_q  <= acnt_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      code_q  <= code_d;
    end
  end

  assign L2R_out    = out_q[0];
  assign D2R_out    = out_q[1];
  assign L2D_out    = out_q[2];
  assign R2L_out    = out_q[3];
  assign fault      = (state_q == StFault);
  assign fault_code = code_q;
  assign mon_state  = state_q;

endmodule

// File: tb/tb_tlc_safety_monitor.sv
// Bench for tlc_safety_monitor: table-driven legal cycle and conflict checked through an
// expected-output queue, then hand-written sequences for the multi-cycle corner cases.
module tb_tlc_safety_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] L2R_in, D2R_in, L2D_in, R2L_in;
  logic       fault_clr;
  logic [2:0] L2R_out, D2R_out, L2D_out, R2L_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] mon_state;

  always #5 clk = ~clk;

  tlc_safety_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .L2R_in    (L2R_in),
    .D2R_in    (D2R_in),
    .L2D_in    (L2D_in),
    .R2L_in    (R2L_in),
    .fault_clr (fault_clr),
    .L2R_out   (L2R_out),
    .D2R_out   (D2R_out),
    .L2D_out   (L2D_out),
    .R2L_out   (R2L_out),
    .fault     (fault),
    .fault_code(fault_code),
    .mon_state (mon_state)
  );

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  // Lamp vectors are packed {L2R, D2R, L2D, R2L}.
  typedef struct {
    logic [11:0] in;
    int          len;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] lamps;
    logic        flt;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  vec_t vecs[6];

  logic [11:0] red_all, dark_all, pat_b, pat_c, pat_seq, pat_sy, pat_enc;

  function automatic logic [11:0] out_lamps();
    return {L2R_out, D2R_out, L2D_out, R2L_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [11:0] pat, input logic clr);
    {L2R_in, D2R_in, L2D_in, R2L_in} = pat;
    fault_clr = clr;
  endtask

  // One clock: new inputs just after the rising edge, outputs sampled on the falling edge.
  task automatic cyc(input logic [11:0] pat, input logic clr);
    @(posedge clk);
    #1;
    drive(pat, clr);
    @(negedge clk);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got empty queue, expected an entry");
    end else begin
      e = sbq.pop_front();
      chk("sb_lamps", out_lamps(), e.lamps);
      chk("sb_fault", fault, e.flt);
    end
  endtask

  // Drive a pattern, queue what must appear two cycles later, check this cycle's entry.
  task automatic sb_step(input logic [11:0] pat, input logic [11:0] exp_l, input logic exp_f);
    exp_t e;
    @(posedge clk);
    #1;
    drive(pat, 1'b0);
    e.lamps = exp_l;
    e.flt   = exp_f;
    sbq.push_back(e);
    @(negedge clk);
    sb_pop();
  endtask

  task automatic sb_drain();
    @(posedge clk);
    @(negedge clk);
    sb_pop();
  endtask

  // Reset with pat applied, release, and run until RUN is reached.
  task automatic reset_to_run(input logic [11:0] pat);
    rst = 1'b0;
    drive(pat, 1'b0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    repeat (5) cyc(pat, 1'b0);
    chk("run_entry_state", mon_state, 2'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          row;
    int          left;
    logic [11:0] p, e;
    logic        seen;

    red_all  = {R, R, R, R};
    dark_all = {D, D, D, D};
    pat_b    = {G, R, R, G};
    pat_c    = {G, G, R, G};
    pat_seq  = {G, R, R, R};
    pat_sy   = {G, R, R, Y};
    pat_enc  = {R, R, D, G};

    vecs[0] = '{in: {G, R, R, G}, len: 8, exp: {G, R, R, G}};
    vecs[1] = '{in: {G, R, R, Y}, len: 3, exp: {G, R, R, Y}};
    vecs[2] = '{in: {G, R, G, R}, len: 6, exp: {G, R, G, R}};
    vecs[3] = '{in: {Y, R, Y, R}, len: 4, exp: {Y, R, Y, R}};
    vecs[4] = '{in: {R, G, R, R}, len: 8, exp: {R, G, R, R}};
    vecs[5] = '{in: {R, Y, R, R}, len: 3, exp: {R, Y, R, R}};

    // Reset state.
    drive(red_all, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_lamps", out_lamps(), red_all);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 3'd0);
    chk("rst_state", mon_state, 2'd0);

    // Legal cycle: 4 red STARTUP cycles, then inputs mirrored 2 cycles later.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(vecs[0].in, 1'b0);
    row  = 0;
    left = vecs[0].len - 1;
    sbq.delete();
    for (int k = 0; k < 2; k++) begin
      exp_t r;
      r.lamps = red_all;
      r.flt   = 1'b0;
      sbq.push_back(r);
    end
    @(negedge clk);
    chk("startup_c1_lamps", out_lamps(), red_all);
    chk("startup_c1_state", mon_state, 2'd0);
    for (int i = 1; i < 200; i++) begin
      if (left == 0) begin
        row  = (row + 1) % 6;
        left = vecs[row].len;
      end
      p = vecs[row].in;
      e = vecs[row].exp;
      left--;
      sb_step(p, (i <= 1) ? red_all : e, 1'b0);
      if (i == 3) chk("startup_c4_state", mon_state, 2'd0);
      if (i == 4) chk("run_c5_state", mon_state, 2'd1);
    end

    // Conflict: one cycle of D2R green alongside L2R/R2L green.
    sb_step(pat_c, red_all, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      sb_step(pat_b, (((k / 4) % 2) == 0) ? red_all : dark_all, 1'b1);
    end
    chk("conflict_code", fault_code, 3'd2);
    chk("conflict_state", mon_state, 2'd2);
    sb_drain();
    sb_drain();

    // Asynchronous reset between edges while flashing (dark phase).
    #2;
    rst = 1'b0;
    #1;
    chk("async_lamps", out_lamps(), red_all);
    chk("async_fault", fault, 1'b0);
    chk("async_code", fault_code, 3'd0);
    chk("async_state", mon_state, 2'd0);

    // Sequence: R2L green straight to red.
    reset_to_run(pat_b);
    cyc(pat_seq, 1'b0);
    cyc(pat_seq, 1'b0);
    chk("seq_masked_lamps", out_lamps(), pat_b);
    chk("seq_masked_fault", fault, 1'b0);
    cyc(pat_seq, 1'b0);
    chk("seq_fault", fault, 1'b1);
    chk("seq_code", fault_code, 3'd3);
    chk("seq_lamps", out_lamps(), red_all);
    cyc(pat_seq, 1'b1);
    cyc(pat_b, 1'b0);
    chk("clr_state", mon_state, 2'd0);
    chk("clr_fault", fault, 1'b0);
    chk("clr_code", fault_code, 3'd0);
    repeat (4) cyc(pat_b, 1'b0);
    chk("clr_run_state", mon_state, 2'd1);

    // Short yellow: R2L yellow for only 2 cycles.
    cyc(pat_sy, 1'b0);
    cyc(pat_sy, 1'b0);
    cyc(pat_seq, 1'b0);
    cyc(pat_seq, 1'b0);
    cyc(pat_seq, 1'b0);
    chk("shorty_fault", fault, 1'b1);
    chk("shorty_code", fault_code, 3'd4);

    // Encoding wins over a simultaneous sequence error.
    reset_to_run(pat_b);
    cyc(pat_enc, 1'b0);
    cyc(pat_enc, 1'b0);
    cyc(pat_enc, 1'b0);
    chk("enc_fault", fault, 1'b1);
    chk("enc_code", fault_code, 3'd1);

    // Stall: inputs held constant.
    reset_to_run(pat_b);
    repeat (10) cyc(pat_b, 1'b0);
    chk("stall_early", fault, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cyc(pat_b, 1'b0);
      if (fault) seen = 1'b1;
    end
    chk("stall_seen", seen, 1'b1);
    chk("stall_code", fault_code, 3'd5);
    chk("stall_lamps", out_lamps(), red_all);
    cyc(pat_b, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(pat_b, 1'b0);
      chk("stall_clr_state", mon_state, 2'd0);
      chk("stall_clr_lamps", out_lamps(), red_all);
    end
    cyc(pat_b, 1'b0);
    chk("stall_rerun_state", mon_state, 2'd1);
    chk("stall_rerun_lamps", out_lamps(), pat_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
